control_unit: RTL

//  Hard-wired Moore FSM that drives every control strobe of the 32-bit bus datapath (register in/out enables, PC/IR/MAR/MDR/Y/Z/HI/LO strobes, ALUselect).

---
 rtl/cpu_pkg.sv | 73 +++++++
 rtl/cu_opcode_decode.sv | 45 ++++
 rtl/control_unit.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the control unit: opcodes, ALU codes, FSM states and
// instruction classes. The optional mul/div/mfhi/mflo group is gated by CU_MULDIV_EN.
package cpu_pkg;

  localparam int OPC_W = 5;

  localparam logic [OPC_W-1:0] OP_LD   = 5'd0;
  localparam logic [OPC_W-1:0] OP_LDI  = 5'd1;
  localparam logic [OPC_W-1:0] OP_ST   = 5'd2;
  localparam logic [OPC_W-1:0] OP_ADD  = 5'd3;
  localparam logic [OPC_W-1:0] OP_SUB  = 5'd4;
  localparam logic [OPC_W-1:0] OP_AND  = 5'd5;
  localparam logic [OPC_W-1:0] OP_OR   = 5'd6;
  localparam logic [OPC_W-1:0] OP_SHR  = 5'd7;
  localparam logic [OPC_W-1:0] OP_SHL  = 5'd8;
  localparam logic [OPC_W-1:0] OP_ROR  = 5'd9;
  localparam logic [OPC_W-1:0] OP_ROL  = 5'd10;
  localparam logic [OPC_W-1:0] OP_ADDI = 5'd11;
  localparam logic [OPC_W-1:0] OP_ANDI = 5'd12;
  localparam logic [OPC_W-1:0] OP_ORI  = 5'd13;
  localparam logic [OPC_W-1:0] OP_MUL  = 5'd14;
  localparam logic [OPC_W-1:0] OP_DIV  = 5'd15;
  localparam logic [OPC_W-1:0] OP_NEG  = 5'd16;
  localparam logic [OPC_W-1:0] OP_NOT  = 5'd17;
  localparam logic [OPC_W-1:0] OP_BR   = 5'd18;
  localparam logic [OPC_W-1:0] OP_MFHI = 5'd23;
  localparam logic [OPC_W-1:0] OP_MFLO = 5'd24;
  localparam logic [OPC_W-1:0] OP_NOP  = 5'd25;
  localparam logic [OPC_W-1:0] OP_HALT = 5'd26;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SHR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_ROR = 4'd6,
    ALU_ROL = 4'd7,
    ALU_NEG = 4'd8,
    ALU_NOT = 4'd9,
    ALU_MUL = 4'd10,
    ALU_DIV = 4'd11
  } alu_op_e;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_F0   = 4'd1,
    S_F1   = 4'd2,
    S_F2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_T7   = 4'd8,
    S_HALT = 4'd9
  } state_e;

  typedef enum logic [3:0] {
    CLS_NOP    = 4'd0,
    CLS_ALU    = 4'd1,
    CLS_IMM    = 4'd2,
    CLS_LD     = 4'd3,
    CLS_LDI    = 4'd4,
    CLS_ST     = 4'd5,
    CLS_BR     = 4'd6,
    CLS_MULDIV = 4'd7,
    CLS_MFHI   = 4'd8,
    CLS_MFLO   = 4'd9,
    CLS_HALT   = 4'd10
  } cls_e;

endpackage

// File: rtl/cu_opcode_decode.sv
// Combinational opcode decoder: IR opcode field -> {instruction class, ALU op}.
// mul/div/mfhi/mflo decode only when CU_MULDIV_EN is defined; otherwise they fall to nop.
module cu_opcode_decode #(
  parameter int OPW = 5
) (
  input  logic [OPW-1:0] opcode,
  output logic [3:0]     cls,
  output logic [3:0]     alu_op
);
  import cpu_pkg::*;

  // NOTE: every output gets a default before the case so no path can infer a latch.
  always_comb begin
    cls    = CLS_NOP;
    alu_op = ALU_ADD;
    case (opcode)
      OP_LD:   cls = CLS_LD;
      OP_LDI:  cls = CLS_LDI;
      OP_ST:   cls = CLS_ST;
      OP_BR:   cls = CLS_BR;
      OP_HALT: cls = CLS_HALT;
      OP_ADD:  begin cls = CLS_ALU; alu_op = ALU_ADD; end
      OP_SUB:  begin cls = CLS_ALU; alu_op = ALU_SUB; end
      OP_AND:  begin cls = CLS_ALU; alu_op = ALU_AND; end
      OP_OR:   begin cls = CLS_ALU; alu_op = ALU_OR;  end
      OP_SHR:  begin cls = CLS_ALU; alu_op = ALU_SHR; end
      OP_SHL:  begin cls = CLS_ALU; alu_op = ALU_SHL; end
      OP_ROR:  begin cls = CLS_ALU; alu_op = ALU_ROR; end
      OP_ROL:  begin cls = CLS_ALU; alu_op = ALU_ROL; end
      OP_NEG:  begin cls = CLS_ALU; alu_op = ALU_NEG; end
      OP_NOT:  begin cls = CLS_ALU; alu_op = ALU_NOT; end
      OP_ADDI: begin cls = CLS_IMM; alu_op = ALU_ADD; end
      OP_ANDI: begin cls = CLS_IMM; alu_op = ALU_AND; end
      OP_ORI:  begin cls = CLS_IMM; alu_op = ALU_OR;  end
`ifdef CU_MULDIV_EN
      OP_MUL:  begin cls = CLS_MULDIV; alu_op = ALU_MUL; end
      OP_DIV:  begin cls = CLS_MULDIV; alu_op = ALU_DIV; end
      OP_MFHI: cls = CLS_MFHI;
      OP_MFLO: cls = CLS_MFLO;
`endif
      default: cls = CLS_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hard-wired Moore control unit sequencing fetch/decode/execute for the bus datapath.
// Optional mul/div/mfhi/mflo support is enabled by defining CU_MULDIV_EN.
module control_unit #(
  parameter int OPW      = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] IR,
  input  logic        CON_FF,
  input  logic        mem_ready,
  input  logic        stop,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        PCin,
  output logic        PCout,
  output logic        IncPC,
  output logic        IRin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Yin,
  output logic        Zin,
  output logic        HIin,
  output logic        LOin,
  output logic        HIout,
  output logic        LOout,
  output logic        Zhighout,
  output logic        Zlowout,
  output logic        Cout,
  output logic        CONin,
  output logic        Read,
  output logic        Write,
  output logic [3:0]  ALUselect,
  output logic        run,
  output logic        mem_err
);
  import cpu_pkg::*;

  localparam int WCW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

  state_e         state_q, state_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  logic           stop_pend_q, stop_pend_d;
  logic           mem_err_q, mem_err_d;

  logic [3:0] cls_raw, alu_raw;
  cls_e       cls;
  logic       running;
  logic       mem_wait;
  logic       instr_end;
  logic       unused_ir_bits;

  cu_opcode_decode #(.OPW(OPW)) u_dec (
    .opcode (IR[31:32-OPW]),
    .cls    (cls_raw),
    .alu_op (alu_raw)
  );

  assign cls            = cls_e'(cls_raw);
  assign unused_ir_bits = ^IR[31-OPW:0];
  assign running        = (state_q != S_RST) && (state_q != S_HALT);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_q     <= S_RST;
      wait_cnt_q  <= '0;
      stop_pend_q <= 1'b0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stop_pend_q <= stop_pend_d;
      mem_err_q   <= mem_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    stop_pend_d = stop_pend_q | (stop & running);
    mem_err_d   = 1'b0;
    mem_wait    = 1'b0;
    instr_end   = 1'b0;

    case (state_q)
      S_RST: state_d = S_F0;
      S_F0:  state_d = S_F1;
      S_F1:  if (mem_ready) state_d = S_F2; else mem_wait = 1'b1;
      S_F2:  state_d = S_T3;
      S_T3: begin
        case (cls)
          CLS_HALT:                     state_d = S_HALT;
          CLS_NOP, CLS_MFHI, CLS_MFLO:  instr_end = 1'b1;
          default:                      state_d = S_T4;
        endcase
      end
      S_T4: state_d = S_T5;
      S_T5: begin
        case (cls)
          CLS_LD, CLS_ST, CLS_BR, CLS_MULDIV: state_d = S_T6;
          default:                            instr_end = 1'b1;
        endcase
      end
      S_T6: begin
        case (cls)
          CLS_LD:  if (mem_ready) state_d = S_T7; else mem_wait = 1'b1;
          CLS_ST:  state_d = S_T7;
          default: instr_end = 1'b1;
        endcase
      end
      S_T7: begin
        if (cls == CLS_ST && !mem_ready) mem_wait  = 1'b1;
        else                             instr_end = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_RST;
    endcase

    // A stalled memory access gives up after MAX_WAIT wait cycles and refetches.
    if (mem_wait) begin
      if (wait_cnt_q == WCW'(MAX_WAIT)) begin
        state_d   = S_F0;
        mem_err_d = 1'b1;
      end else begin
        wait_cnt_d = wait_cnt_q + 1'b1;
      end
    end

    if (instr_end) begin
      state_d     = (stop_pend_q || stop) ? S_HALT : S_F0;
      stop_pend_d = 1'b0;
    end

    if (state_d != state_q) wait_cnt_d = '0;
  end

  always_comb begin
    Gra = 1'b0; Grb = 1'b0; Grc = 1'b0; Rin = 1'b0; Rout = 1'b0; BAout = 1'b0;
    PCin = 1'b0; PCout = 1'b0; IncPC = 1'b0; IRin = 1'b0; MARin = 1'b0;
    MDRin = 1'b0; MDRout = 1'b0; Yin = 1'b0; Zin = 1'b0;
    HIin = 1'b0; LOin = 1'b0; HIout = 1'b0; LOout = 1'b0; Zhighout = 1'b0;
    Zlowout = 1'b0; Cout = 1'b0; CONin = 1'b0; Read = 1'b0; Write = 1'b0;
    ALUselect = ALU_ADD;
    run = running;

    case (state_q)
      S_F0: begin PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1; end
      S_F1: begin Zlowout = 1'b1; PCin = 1'b1; Read = 1'b1; MDRin = 1'b1; end
      S_F2: begin MDRout = 1'b1; IRin = 1'b1; end
      S_T3: begin
        case (cls)
          CLS_ALU, CLS_IMM:        begin Grb = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_LD, CLS_LDI, CLS_ST: begin Grb = 1'b1; BAout = 1'b1; Yin = 1'b1; end
          CLS_BR:                  begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
`ifdef CU_MULDIV_EN
          CLS_MULDIV:              begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
          CLS_MFHI:                begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_MFLO:                begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`endif
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          CLS_ALU:                 begin Grc = 1'b1; Rout = 1'b1; ALUselect = alu_raw; Zin = 1'b1; end
          CLS_IMM:                 begin Cout = 1'b1; ALUselect = alu_raw; Zin = 1'b1; end
          CLS_LD, CLS_LDI, CLS_ST: begin Cout = 1'b1; Zin = 1'b1; end
          CLS_BR:                  begin PCout = 1'b1; Yin = 1'b1; end
`ifdef CU_MULDIV_EN
          CLS_MULDIV:              begin Grb = 1'b1; Rout = 1'b1; ALUselect = alu_raw; Zin = 1'b1; end
`endif
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          CLS_ALU, CLS_IMM, CLS_LDI: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_LD, CLS_ST:            begin Zlowout = 1'b1; MARin = 1'b1; end
          CLS_BR:                    begin Cout = 1'b1; Zin = 1'b1; end
`ifdef CU_MULDIV_EN
          CLS_MULDIV:                begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          CLS_LD:     begin Read = 1'b1; MDRin = 1'b1; end
          CLS_ST:     begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
          CLS_BR:     begin Zlowout = CON_FF; PCin = CON_FF; end
`ifdef CU_MULDIV_EN
          CLS_MULDIV: begin Zhighout = 1'b1; HIin = 1'b1; end
`endif
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          CLS_LD:  begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          CLS_ST:  begin MDRout = 1'b1; Write = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign mem_err = mem_err_q;

endmodule
